// File: rtl/gp_register_bank.sv
// Parametrised general-purpose register bank: 8-op function set, per-register enables, two read ports.
// Optional saturating inc/dec when GP_REGISTER_BANK_SAT_EN is defined.
module gp_register_bank #(
    parameter int NBits = 16,
    parameter int NRegs = 4,
    localparam int SelBits = $clog2(NRegs)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2:0]         funsel,
    input  logic [NRegs-1:0]   e,
    input  logic [NBits-1:0]   i,
    input  logic [SelBits-1:0] osel_a,
    input  logic [SelBits-1:0] osel_b,
    output logic [NBits-1:0]   q_a,
    output logic [NBits-1:0]   q_b,
    output logic               zero_a,
    output logic               wrap
);

    localparam int Half  = NBits / 2;
    localparam int NRead = 2 ** SelBits;

    logic [NBits-1:0] regs    [NRegs];
    logic [NBits-1:0] regs_nx [NRegs];
    logic [NBits-1:0] rd      [NRead];
    logic             wrap_nx;

    always_comb begin
        wrap_nx = 1'b0;
        for (int k = 0; k < NRegs; k++) begin
            regs_nx[k] = regs[k];
            if (e[k]) begin
                case (funsel)
                    3'b000: regs_nx[k] = '0;
                    3'b001: regs_nx[k] = i;
                    3'b010: begin
                        if (regs[k] == '0) begin
                            wrap_nx = 1'b1;
`ifdef GP_REGISTER_BANK_SAT_EN
                            regs_nx[k] = '0;
`else
                            regs_nx[k] = '1;
`endif
                        end else begin
                            regs_nx[k] = regs[k] - NBits'(1);
                        end
                    end
                    3'b011: begin
                        if (regs[k] == '1) begin
                            wrap_nx = 1'b1;
`ifdef GP_REGISTER_BANK_SAT_EN
                            regs_nx[k] = '1;
`else
                            regs_nx[k] = '0;
`endif
                        end else begin
                            regs_nx[k] = regs[k] + NBits'(1);
                        end
                    end
                    3'b100: regs_nx[k][Half-1:0] = i[Half-1:0];
                    3'b101: regs_nx[k][NBits-1:Half] = i[Half-1:0];
                    3'b110: begin
                        wrap_nx = wrap_nx | regs[k][NBits-1];
                        regs_nx[k] = {regs[k][NBits-2:0], 1'b0};
                    end
                    3'b111: begin
                        wrap_nx = wrap_nx | regs[k][0];
                        regs_nx[k] = {1'b0, regs[k][NBits-1:1]};
                    end
                    default: regs_nx[k] = regs[k];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NRegs; k++) regs[k] <= '0;
            wrap <= 1'b0;
        end else begin
            for (int k = 0; k < NRegs; k++) regs[k] <= regs_nx[k];
            wrap <= wrap_nx;
        end
    end

    // Unpopulated select codes read as zero.
    for (genvar g = 0; g < NRead; g++) begin : g_rd
        if (g < NRegs) begin : g_live
            assign rd[g] = regs[g];
        end else begin : g_pad
            assign rd[g] = '0;
        end
    end

    assign q_a    = rd[osel_a];
    assign q_b    = rd[osel_b];
    assign zero_a = (q_a == '0);

endmodule
